// File: rtl/asip_branch_pkg.sv
// ---------------------------------------------------------------------------
// asip_branch_pkg
// Shared types and constants for the branch-resolution controller.
//   cond_e    : 3-bit branch condition codes (110/111 are undefined)
//   state_e   : controller FSM states
//   flags_t   : architectural NZCV flag register layout {n,z,c,v}
//   OP_BRANCH : op class of a conditional branch; any other op is a jump
// ---------------------------------------------------------------------------
package asip_branch_pkg;

    typedef enum logic [2:0] {
        AL = 3'b000,
        EQ = 3'b001,
        LT = 3'b010,
        GT = 3'b011,
        LE = 3'b100,
        GE = 3'b101
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EVAL  = 2'b01,
        FLUSH = 2'b10
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic [1:0] OP_BRANCH = 2'b10;

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational branch-condition evaluator.
// Ports:
//   flags   in  flags_t  NZCV flags to test against
//   cond    in  3        condition code
//   op      in  2        instruction op class
//   taken   out 1        branch is taken
//   illegal out 1        condition code is undefined (only for real branches)
// ---------------------------------------------------------------------------
module cond_eval
    import asip_branch_pkg::*;
(
    input  flags_t     flags,
    input  logic [2:0] cond,
    input  logic [1:0] op,
    output logic       taken,
    output logic       illegal
);

    logic lt;
    logic unused_carry;

    // Signed less-than: negative result unless the subtraction overflowed.
    assign lt = flags.n ^ flags.v;

    // No supported condition looks at the carry flag.
    assign unused_carry = flags.c;

    // Anything that is not a conditional branch behaves as AL (a jump), so
    // the condition field is ignored and can never be flagged illegal.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (op != OP_BRANCH) begin
            taken = 1'b1;
        end else begin
            case (cond)
                AL:      taken = 1'b1;
                EQ:      taken = flags.z;
                LT:      taken = lt;
                GT:      taken = ~flags.z & ~lt;
                LE:      taken = flags.z | lt;
                GE:      taken = ~lt;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Sequential branch-resolution controller. Owns the NZCV flag register,
// accepts one branch request at a time through br_valid/br_ready, resolves
// it in a dedicated EVAL cycle, redirects the PC on a taken branch and then
// holds the front end in flush for FLUSH_CYCLES cycles. Keeps saturating
// taken / not-taken counters for the performance registers.
//
// Optional feature macro: FLAG_FWD_EN
//   defined   : a flag write in the EVAL cycle is forwarded into evaluation
//   undefined : EVAL always sees the registered flags (decode adds a bubble)
//
// Ports:
//   clk           in   core clock, rising edge
//   reset         in   asynchronous, active-low reset
//   flag_we       in   write alu_flags into the flag register
//   alu_flags     in   {N,Z,C,V} from the ALU
//   br_valid      in   branch request valid
//   br_ready      out  controller can accept a request (IDLE)
//   br_op         in   op class, only OP_BRANCH is conditional
//   br_cond       in   condition code
//   br_target     in   branch target address
//   pc_load       out  one-cycle pulse, load pc_target into the PC
//   pc_target     out  redirect address, zero unless pc_load
//   flush         out  squash fetch/decode
//   stall         out  hold decode while busy
//   br_done       out  one-cycle pulse, branch resolved
//   br_taken      out  resolution result, valid with br_done
//   cond_illegal  out  undefined condition code, pulses with br_done
//   flags_q       out  current flag register
//   taken_cnt     out  saturating taken-branch counter
//   nt_cnt        out  saturating not-taken-branch counter
// ---------------------------------------------------------------------------
module branch_ctrl
    import asip_branch_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic [3:0]        alu_flags,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_op,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              stall,
    output logic              br_done,
    output logic              br_taken,
    output logic              cond_illegal,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nt_cnt
);

    // The flush counter counts down to zero, so it starts one below the
    // requested flush length. With a zero length FLUSH is never entered.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);

    state_e            state;
    state_e            state_next;
    logic [1:0]        op_q;
    logic [2:0]        cond_q;
    logic [ADDR_W-1:0] target_q;
    flags_t            flags_r;
    flags_t            eval_flags;
    logic [3:0]        flush_cnt;
    logic              cond_taken;
    logic              cond_bad;

`ifdef FLAG_FWD_EN
    // A compare in the same cycle as EVAL wins over the stale register.
    assign eval_flags = flag_we ? flags_t'(alu_flags) : flags_r;
`else
    assign eval_flags = flags_r;
`endif

    cond_eval u_cond_eval (
        .flags   (eval_flags),
        .cond    (cond_q),
        .op      (op_q),
        .taken   (cond_taken),
        .illegal (cond_bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request payload is only captured on the accepting IDLE cycle, so it
    // stays stable through EVAL regardless of what decode drives next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= 2'b00;
            cond_q   <= 3'b000;
            target_q <= '0;
        end else if (state == IDLE && br_valid) begin
            op_q     <= br_op;
            cond_q   <= br_cond;
            target_q <= br_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= '0;
        end else if (flag_we) begin
            flags_r <= flags_t'(alu_flags);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt <= 4'd0;
        end else if (state == EVAL && cond_taken) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (state == FLUSH && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    always_comb begin
        state_next   = state;
        br_ready     = 1'b0;
        pc_load      = 1'b0;
        pc_target    = '0;
        flush        = 1'b0;
        br_done      = 1'b0;
        br_taken     = 1'b0;
        cond_illegal = 1'b0;
        case (state)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                br_done      = 1'b1;
                br_taken     = cond_taken;
                cond_illegal = cond_bad;
                if (cond_taken) begin
                    pc_load    = 1'b1;
                    pc_target  = target_q;
                    state_next = HAS_FLUSH ? FLUSH : IDLE;
                end else begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (flush_cnt == 4'd0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall   = (state != IDLE);
    assign flags_q = flags_r;

    // Illegal codes resolve as not taken and are counted as such.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt <= '0;
            nt_cnt    <= '0;
        end else if (br_done) begin
            if (br_taken) begin
                if (taken_cnt != '1) begin
                    taken_cnt <= taken_cnt + 1'b1;
                end
            end else begin
                if (nt_cnt != '1) begin
                    nt_cnt <= nt_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Directed bench for branch_ctrl with FLUSH_CYCLES=2 and CNT_W=2 so that
// counter saturation is reachable in a handful of branches. Expected values
// are hand-derived from the condition table and cycle timing.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

    logic        clk;
    logic        reset;
    logic        flag_we;
    logic [3:0]  alu_flags;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_op;
    logic [2:0]  br_cond;
    logic [31:0] br_target;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        flush;
    logic        stall;
    logic        br_done;
    logic        br_taken;
    logic        cond_illegal;
    logic [3:0]  flags_q;
    logic [1:0]  taken_cnt;
    logic [1:0]  nt_cnt;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    branch_ctrl #(
        .ADDR_W       (32),
        .FLUSH_CYCLES (2),
        .CNT_W        (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flag_we      (flag_we),
        .alu_flags    (alu_flags),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_op        (br_op),
        .br_cond      (br_cond),
        .br_target    (br_target),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .flush        (flush),
        .stall        (stall),
        .br_done      (br_done),
        .br_taken     (br_taken),
        .cond_illegal (cond_illegal),
        .flags_q      (flags_q),
        .taken_cnt    (taken_cnt),
        .nt_cnt       (nt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                 input logic [2:0] cond, input logic [31:0] target,
                                 input logic we, input logic [3:0] flags);
        br_valid  = valid;
        br_op     = op;
        br_cond   = cond;
        br_target = target;
        flag_we   = we;
        alu_flags = flags;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 4'b0000);
    endtask

    // Condition table vectors: flags, cond, expected taken.
    logic [3:0] vec_flags [5] = '{4'b1000, 4'b1001, 4'b0100, 4'b0001, 4'b0000};
    logic [2:0] vec_cond  [5] = '{3'b010,  3'b010,  3'b100,  3'b101,  3'b101};
    logic       vec_taken [5] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1};

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();

        // Reset state
        checkOutput("rst_br_ready", br_ready, 1);
        checkOutput("rst_pc_load", pc_load, 0);
        checkOutput("rst_pc_target", pc_target, 0);
        checkOutput("rst_flush", flush, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_br_done", br_done, 0);
        checkOutput("rst_br_taken", br_taken, 0);
        checkOutput("rst_cond_illegal", cond_illegal, 0);
        checkOutput("rst_flags_q", flags_q, 0);
        checkOutput("rst_taken_cnt", taken_cnt, 0);
        checkOutput("rst_nt_cnt", nt_cnt, 0);
        reset = 1'b1;
        tick();

        // EQ taken: flags written at T-2, request at T
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 1'b1, 4'b0100);
        tick();
        idle();
        tick();
        checkOutput("eq_flags_q", flags_q, 4'b0100);
        applyStimulus(1'b1, 2'b10, 3'b001, 32'h100, 1'b0, 4'b0000);
        checkOutput("eq_ready_T", br_ready, 1);
        tick();
        idle();
        checkOutput("eq_pc_load", pc_load, 1);
        checkOutput("eq_pc_target", pc_target, 32'h100);
        checkOutput("eq_br_done", br_done, 1);
        checkOutput("eq_br_taken", br_taken, 1);
        checkOutput("eq_stall_T1", stall, 1);
        checkOutput("eq_ready_T1", br_ready, 0);
        checkOutput("eq_flush_T1", flush, 0);
        tick();
        checkOutput("eq_flush_T2", flush, 1);
        checkOutput("eq_pc_load_T2", pc_load, 0);
        checkOutput("eq_taken_cnt", taken_cnt, 1);
        tick();
        checkOutput("eq_flush_T3", flush, 1);
        checkOutput("eq_ready_T3", br_ready, 0);
        tick();
        checkOutput("eq_flush_T4", flush, 0);
        checkOutput("eq_ready_T4", br_ready, 1);
        checkOutput("eq_stall_T4", stall, 0);

        // GT not taken with N=1, V=0
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 1'b1, 4'b1000);
        tick();
        applyStimulus(1'b1, 2'b10, 3'b011, 32'h200, 1'b0, 4'b0000);
        tick();
        idle();
        checkOutput("gt_br_done", br_done, 1);
        checkOutput("gt_br_taken", br_taken, 0);
        checkOutput("gt_pc_load", pc_load, 0);
        checkOutput("gt_illegal", cond_illegal, 0);
        tick();
        checkOutput("gt_flush_T2", flush, 0);
        checkOutput("gt_ready_T2", br_ready, 1);
        checkOutput("gt_nt_cnt", nt_cnt, 1);

        // Forwarding: flags_q=0000, flag write of 0100 during EVAL, cond EQ
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 1'b1, 4'b0000);
        tick();
        applyStimulus(1'b1, 2'b10, 3'b001, 32'h240, 1'b0, 4'b0000);
        tick();
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 1'b1, 4'b0100);
        checkOutput("fwd_br_taken", br_taken, FWD);
        checkOutput("fwd_pc_load", pc_load, FWD);
        tick();
        idle();
        checkOutput("fwd_flags_q", flags_q, 4'b0100);
        checkOutput("fwd_taken_cnt", taken_cnt, FWD ? 2 : 1);
        checkOutput("fwd_nt_cnt", nt_cnt, FWD ? 1 : 2);
        tick();
        tick();
        checkOutput("fwd_ready", br_ready, 1);

        // Illegal condition on a real branch
        applyStimulus(1'b1, 2'b10, 3'b110, 32'h280, 1'b0, 4'b0000);
        tick();
        idle();
        checkOutput("ill_illegal", cond_illegal, 1);
        checkOutput("ill_br_taken", br_taken, 0);
        checkOutput("ill_br_done", br_done, 1);
        checkOutput("ill_pc_load", pc_load, 0);
        tick();
        checkOutput("ill_nt_cnt", nt_cnt, FWD ? 2 : 3);
        checkOutput("ill_ready", br_ready, 1);

        // Non-branch op with undefined cond behaves as AL
        applyStimulus(1'b1, 2'b01, 3'b110, 32'h300, 1'b0, 4'b0000);
        tick();
        idle();
        checkOutput("jmp_br_taken", br_taken, 1);
        checkOutput("jmp_pc_load", pc_load, 1);
        checkOutput("jmp_pc_target", pc_target, 32'h300);
        checkOutput("jmp_illegal", cond_illegal, 0);
        tick();
        checkOutput("jmp_taken_cnt", taken_cnt, FWD ? 3 : 2);
        tick();
        tick();
        checkOutput("jmp_ready", br_ready, 1);

        // LT / LE / GE condition table
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 1'b1, vec_flags[i]);
            tick();
            applyStimulus(1'b1, 2'b10, vec_cond[i], 32'h400 + 32'(i), 1'b0, 4'b0000);
            tick();
            idle();
            checkOutput($sformatf("tbl%0d_taken", i), br_taken, vec_taken[i]);
            checkOutput($sformatf("tbl%0d_pc_load", i), pc_load, vec_taken[i]);
            tick();
            tick();
            tick();
        end

        // Reset arriving mid-flush
        applyStimulus(1'b1, 2'b10, 3'b000, 32'h500, 1'b0, 4'b0000);
        tick();
        idle();
        checkOutput("mid_pc_load", pc_load, 1);
        tick();
        checkOutput("mid_flush_before", flush, 1);
        reset = 1'b0;
        #1;
        checkOutput("mid_flush", flush, 0);
        checkOutput("mid_stall", stall, 0);
        checkOutput("mid_ready", br_ready, 1);
        checkOutput("mid_taken_cnt", taken_cnt, 0);
        checkOutput("mid_nt_cnt", nt_cnt, 0);
        checkOutput("mid_flags_q", flags_q, 0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("post_pc_load", pc_load, 0);
        checkOutput("post_ready", br_ready, 1);
        tick();
        checkOutput("post_pc_load2", pc_load, 0);
        checkOutput("post_flush", flush, 0);

        // Saturation: five taken branches into a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b10, 3'b000, 32'h600, 1'b0, 4'b0000);
            tick();
            idle();
            tick();
            tick();
            tick();
            checkOutput($sformatf("sat%0d_taken_cnt", i), taken_cnt, (i < 3) ? i + 1 : 3);
        end
        checkOutput("sat_nt_cnt", nt_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
